// File: rtl/bcd_score_accum.sv
// Serial digit-per-cycle BCD score accumulator with valid/ready add requests,
// saturation/wrap on overflow and an optional high-score register (BCD_SCORE_HISCORE_EN).
module bcd_score_accum #(
  parameter int NUM_DIGITS     = 4,
  parameter int SAT_EN_DEFAULT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    add_valid,
  output logic                    add_ready,
  input  logic [4*NUM_DIGITS-1:0] add_bcd,
  output logic [4*NUM_DIGITS-1:0] score,
  output logic                    done,
  output logic                    sat,
  output logic [4*NUM_DIGITS-1:0] hiscore
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam logic [4*NUM_DIGITS-1:0] ALL9 = {NUM_DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE, ADD, COMMIT} state_t;

  state_t                       state;
  logic [NUM_DIGITS-1:0][3:0]   op, work, add_dig, op_clamp;
  logic [IW-1:0]                idx;
  logic                         carry;
  logic [4:0]                   dsum;
  logic [3:0]                   dres;
  logic [4*NUM_DIGITS-1:0]      commit_val;

  assign add_dig = add_bcd;

  // Non-BCD operand digits are forced to 9 so the serial adder only sees 0..9.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_clamp
    assign op_clamp[g] = (add_dig[g] > 4'd9) ? 4'd9 : add_dig[g];
  end

  always_comb begin
    dsum       = {1'b0, work[idx]} + {1'b0, op[idx]} + {4'd0, carry};
    dres       = (dsum > 5'd9) ? 4'(dsum - 5'd10) : dsum[3:0];
    commit_val = (carry && SAT_EN_DEFAULT != 0) ? ALL9 : work;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      add_ready <= 1'b1;
      score     <= '0;
      sat       <= 1'b0;
      done      <= 1'b0;
      op        <= '0;
      work      <= '0;
      idx       <= '0;
      carry     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        state     <= IDLE;
        add_ready <= 1'b1;
        score     <= '0;
        sat       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            add_ready <= 1'b1;
            if (add_valid) begin
              op        <= op_clamp;
              work      <= score;
              idx       <= '0;
              carry     <= 1'b0;
              add_ready <= 1'b0;
              state     <= ADD;
            end
          end
          ADD: begin
            work[idx] <= dres;
            carry     <= (dsum > 5'd9);
            idx       <= idx + 1'b1;
            if (idx == LAST) state <= COMMIT;
          end
          COMMIT: begin
            score     <= commit_val;
            if (carry) sat <= 1'b1;
            done      <= 1'b1;
            add_ready <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef BCD_SCORE_HISCORE_EN
  // Packed valid BCD orders the same as its decimal value, MSD first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      hiscore <= '0;
    else if (state == COMMIT && !clr && commit_val > hiscore)
      hiscore <= commit_val;
  end
`else
  assign hiscore = '0;
`endif

endmodule

// File: tb/tb_bcd_score_accum.sv
// Randomized self-checking bench for bcd_score_accum against an integer-arithmetic score model.
module tb_bcd_score_accum;
  localparam int N   = 4;
  localparam int SAT = 1;
  localparam int W   = 4 * N;
  localparam int MOD = 10 ** N;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clr = 1'b0;
  logic         add_valid = 1'b0;
  logic         add_ready, done, sat;
  logic [W-1:0] add_bcd = '0;
  logic [W-1:0] score, hiscore;

  int vectors = 0;
  int miscompares = 0;
  int unsigned m_score = 0, m_hi = 0;
  bit m_sat = 0;

  bcd_score_accum #(.NUM_DIGITS(N), .SAT_EN_DEFAULT(SAT)) dut (
    .clk(clk), .rst(rst), .clr(clr), .add_valid(add_valid), .add_ready(add_ready),
    .add_bcd(add_bcd), .score(score), .done(done), .sat(sat), .hiscore(hiscore)
  );

  always #5 clk = ~clk;

  function automatic int unsigned bcd2int_clamped(input logic [W-1:0] b);
    int unsigned v = 0;
    int unsigned d;
    for (int i = N - 1; i >= 0; i--) begin
      d = b[4*i +: 4];
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int unsigned v);
    logic [W-1:0] b = '0;
    int unsigned t = v;
    for (int i = 0; i < N; i++) begin
      b[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  function automatic void model_add(input logic [W-1:0] amt);
    int unsigned s = m_score + bcd2int_clamped(amt);
    if (s >= MOD) begin
      m_sat   = 1;
      m_score = (SAT != 0) ? MOD - 1 : s - MOD;
    end else begin
      m_score = s;
    end
    if (m_score > m_hi) m_hi = m_score;
  endfunction

  function automatic logic [W-1:0] exp_hi();
`ifdef BCD_SCORE_HISCORE_EN
    return int2bcd(m_hi);
`else
    return '0;
`endif
  endfunction

  task automatic do_add(input logic [W-1:0] amt, input string tag);
    logic [W-1:0] old;
    int t = 0;
    while (add_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (t >= 50) begin
      miscompares++;
      $display("FAIL %s ready_timeout: add_ready=%b required 1", tag, add_ready);
    end
    old = int2bcd(m_score);
    add_valid = 1'b1;
    add_bcd   = amt;
    @(negedge clk);
    add_valid = 1'b0;
    for (int k = 0; k <= N; k++) begin
      vectors++;
      if ({add_ready, done, score} !== {1'b0, 1'b0, old}) begin
        miscompares++;
        $display("FAIL %s busy_cyc%0d: ready=%b done=%b score=%h required 0 0 %h",
                 tag, k, add_ready, done, score, old);
      end
      @(negedge clk);
    end
    model_add(amt);
    vectors++;
    if ({score, sat, done, add_ready, hiscore} !== {int2bcd(m_score), m_sat, 1'b1, 1'b1, exp_hi()}) begin
      miscompares++;
      $display("FAIL %s commit: score=%h sat=%b done=%b ready=%b hi=%h required %h %b 1 1 %h",
               tag, score, sat, done, add_ready, hiscore, int2bcd(m_score), m_sat, exp_hi());
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done_width: done=%b required 0", tag, done);
    end
  endtask

  task automatic do_clr(input string tag);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_score = 0;
    m_sat   = 0;
    vectors++;
    if ({score, sat, done, add_ready} !== {{W{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL %s clr: score=%h sat=%b done=%b ready=%b required 0 0 0 1",
               tag, score, sat, done, add_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    m_score = 0; m_sat = 0; m_hi = 0;
    vectors++;
    if ({score, sat, done, hiscore} !== '0) begin
      miscompares++;
      $display("FAIL reset_hold: score=%h sat=%b done=%b hi=%h required all 0", score, sat, done, hiscore);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({score, sat, done, add_ready} !== {{W{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_release: score=%h sat=%b done=%b ready=%b required 0 0 0 1",
               score, sat, done, add_ready);
    end
  endtask

  task automatic test_basic();
    do_clr("basic");
    do_add(16'h0997, "basic_pre");
    do_add(16'h0005, "basic_carry");
    do_add(16'h0000, "basic_zero");
  endtask

  task automatic test_overflow();
    do_clr("ovf");
    do_add(16'h9990, "ovf_pre");
    do_add(16'h0020, "ovf_add");
    do_add(16'h0001, "ovf_sticky");
    do_clr("ovf_clr");
  endtask

  task automatic test_clamp_ignore();
    do_clr("clamp");
    add_valid = 1'b1;
    add_bcd   = 16'h000C;
    @(negedge clk);
    add_valid = 1'b0;
    @(negedge clk);
    add_valid = 1'b1;
    add_bcd   = 16'h0005;
    @(negedge clk);
    add_valid = 1'b0;
    repeat (N - 1) @(negedge clk);
    model_add(16'h000C);
    vectors++;
    if ({score, done} !== {int2bcd(m_score), 1'b1}) begin
      miscompares++;
      $display("FAIL clamp_commit: score=%h done=%b required %h 1", score, done, int2bcd(m_score));
    end
    repeat (N + 3) @(negedge clk);
    vectors++;
    if ({score, done, add_ready} !== {int2bcd(m_score), 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL clamp_ignored: score=%h done=%b ready=%b required %h 0 1",
               score, done, add_ready, int2bcd(m_score));
    end
  endtask

  task automatic test_clr_mid();
    int dones = 0;
    add_valid = 1'b1;
    add_bcd   = 16'h0100;
    @(negedge clk);
    add_valid = 1'b0;
    @(negedge clk);
    do_clr("clr_mid");
    repeat (N + 3) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    vectors++;
    if ({dones, score} !== {32'd0, {W{1'b0}}}) begin
      miscompares++;
      $display("FAIL clr_mid_after: dones=%0d score=%h required 0 0", dones, score);
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    do_clr("b2b");
    add_valid = 1'b1;
    add_bcd   = 16'h0001;
    repeat (3 * (N + 2)) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    add_valid = 1'b0;
    repeat (3) model_add(16'h0001);
    vectors++;
    if (dones !== 3 || score !== int2bcd(m_score)) begin
      miscompares++;
      $display("FAIL b2b: dones=%0d score=%h required 3 %h", dones, score, int2bcd(m_score));
    end
  endtask

  task automatic test_random();
    logic [W-1:0] amt;
    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 0) do_clr("rand");
      amt = W'($urandom);
      if (i % 3 != 0) amt[W-1 -: 4] = 4'($urandom_range(0, 2));
      do_add(amt, "rand");
    end
  endtask

  task automatic test_reset_mid();
    do_clr("rmid");
    do_add(16'h0042, "rmid_pre");
    add_valid = 1'b1;
    add_bcd   = 16'h0123;
    @(negedge clk);
    add_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    m_score = 0; m_sat = 0; m_hi = 0;
    vectors++;
    if ({score, sat, done, add_ready, hiscore} !== {{W{1'b0}}, 1'b0, 1'b0, 1'b1, {W{1'b0}}}) begin
      miscompares++;
      $display("FAIL reset_mid: score=%h sat=%b done=%b ready=%b hi=%h required 0 0 0 1 0",
               score, sat, done, add_ready, hiscore);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_add(16'h0007, "rmid_post");
  endtask

  task automatic test_hiscore();
`ifdef BCD_SCORE_HISCORE_EN
    do_add(16'h0500, "hi_a");
    do_add(16'h0300, "hi_b");
    do_clr("hi_clr");
    vectors++;
    if (hiscore !== 16'h0800) begin
      miscompares++;
      $display("FAIL hi_keep_clr: hi=%h required 0800", hiscore);
    end
    do_add(16'h0300, "hi_c");
    do_add(16'h0600, "hi_d");
    rst = 1'b0;
    @(negedge clk);
    m_score = 0; m_sat = 0; m_hi = 0;
    vectors++;
    if (hiscore !== '0) begin
      miscompares++;
      $display("FAIL hi_reset: hi=%h required 0000", hiscore);
    end
    rst = 1'b1;
    @(negedge clk);
`else
    do_add(16'h0800, "hi_off");
    do_clr("hi_off_clr");
`endif
  endtask

  initial begin
    test_reset();
    test_hiscore();
    test_basic();
    test_overflow();
    test_clamp_ignore();
    test_clr_mid();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
